// File: rtl/dbg_cmd_pkg.sv
// Shared types and default constants for the JTAG debug command decoder.
package dbg_cmd_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  localparam int DEF_IR_WIDTH    = 2;
  localparam int DEF_DR_WIDTH    = 38;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_ACT_BIT     = 34;
  localparam int DEF_CNT_WIDTH   = 8;

endpackage

// File: rtl/dbg_cmd_decoder_if.sv
// Command bus between the TCK-side capture logic / consumer and the decoder.
interface dbg_cmd_decoder_if
  import dbg_cmd_pkg::*;
#(
  parameter int IR_WIDTH  = DEF_IR_WIDTH,
  parameter int DR_WIDTH  = DEF_DR_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) ();

  logic                   vs_udr;
  logic                   vs_uir;
  logic [IR_WIDTH-1:0]    ir_in;
  logic [DR_WIDTH-1:0]    sr;
  logic                   cmd_ready;
  logic                   clr_overrun;
  logic [DR_WIDTH-1:0]    jdo;
  logic                   cmd_valid;
  logic [2**IR_WIDTH-1:0] take_action;
  logic [2**IR_WIDTH-1:0] take_no_action;
  logic                   ir_update;
  logic                   overrun;
  logic [CNT_WIDTH-1:0]   drop_count;

  modport slave (
    input  vs_udr, vs_uir, ir_in, sr, cmd_ready, clr_overrun,
    output jdo, cmd_valid, take_action, take_no_action, ir_update, overrun, drop_count
  );

  modport master (
    output vs_udr, vs_uir, ir_in, sr, cmd_ready, clr_overrun,
    input  jdo, cmd_valid, take_action, take_no_action, ir_update, overrun, drop_count
  );

endinterface

// File: rtl/dbg_bit_sync.sv
// Level synchroniser plus rising-edge detector for a TCK-domain strobe.
module dbg_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic [STAGES-1:0] fill;
  logic              prev;
  logic              armed;

  // armed only after a genuine low has reached the chain output, so a strobe
  // already high when reset releases is not mistaken for a new edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
      fill  <= '0;
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      fill  <= {fill[STAGES-2:0], 1'b1};
      prev  <= chain[STAGES-1];
      if (fill[STAGES-1] && !chain[STAGES-1])
        armed <= 1'b1;
    end
  end

  assign rise = chain[STAGES-1] & ~prev & armed;

endmodule

// File: rtl/dbg_cmd_decoder.sv
// Decodes synchronised JTAG update-DR strobes into one-hot action pulses with a one-deep command buffer.
module dbg_cmd_decoder
  import dbg_cmd_pkg::*;
#(
  parameter int IR_WIDTH    = DEF_IR_WIDTH,
  parameter int DR_WIDTH    = DEF_DR_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int ACT_BIT     = DEF_ACT_BIT,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  dbg_cmd_decoder_if.slave   bus
);

  localparam int NCH = 2**IR_WIDTH;

  state_e              state;
  logic [IR_WIDTH-1:0] ir_q;
  logic                act_q;
  logic                udr_rise;
  logic                uir_rise;
  logic                xfer;
  logic                drop;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  function automatic logic [NCH-1:0] onehot(input logic [IR_WIDTH-1:0] idx);
    logic [NCH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  dbg_bit_sync #(.STAGES(SYNC_STAGES)) u_udr_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.vs_udr),
    .rise    (udr_rise)
  );

  dbg_bit_sync #(.STAGES(SYNC_STAGES)) u_uir_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (bus.vs_uir),
    .rise    (uir_rise)
  );

  assign bus.cmd_valid = (state == PEND);
  assign xfer          = bus.cmd_valid & bus.cmd_ready;
  assign drop          = (state == PEND) & udr_rise & ~xfer;

  // pulses are combinational so they coincide with the handshake cycle
  assign bus.take_action    = (xfer &&  act_q) ? onehot(ir_q) : '0;
  assign bus.take_no_action = (xfer && !act_q) ? onehot(ir_q) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      bus.jdo        <= '0;
      ir_q           <= '0;
      act_q          <= 1'b0;
      bus.ir_update  <= 1'b0;
      bus.overrun    <= 1'b0;
      bus.drop_count <= '0;
    end else begin
      bus.ir_update <= uir_rise;

      case (state)
        IDLE: begin
          if (udr_rise) begin
            bus.jdo <= bus.sr;
            ir_q    <= bus.ir_in;
            act_q   <= bus.sr[ACT_BIT];
            state   <= PEND;
          end
        end
        PEND: begin
          // a new edge coinciding with a transfer refills the buffer directly
          if (udr_rise && xfer) begin
            bus.jdo <= bus.sr;
            ir_q    <= bus.ir_in;
            act_q   <= bus.sr[ACT_BIT];
          end else if (xfer) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (bus.clr_overrun) begin
        bus.overrun    <= 1'b0;
        bus.drop_count <= '0;
      end else if (drop) begin
        bus.overrun    <= 1'b1;
        bus.drop_count <= sat_inc(bus.drop_count);
      end
    end
  end

endmodule

// File: tb/tb_dbg_cmd_decoder.sv
// Scoreboard bench for dbg_cmd_decoder: expected pulses queued at stimulus, checked when the DUT emits them.
module tb_dbg_cmd_decoder;

  localparam int IRW = 2;
  localparam int DRW = 38;
  localparam int SS  = 2;
  localparam int AB  = 34;
  localparam int CW  = 2;
  localparam int NCH = 4;

  typedef struct packed {
    logic [NCH-1:0] ta;
    logic [NCH-1:0] tna;
    logic [DRW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  dbg_cmd_decoder_if #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .CNT_WIDTH(CW)) bus ();

  dbg_cmd_decoder #(
    .IR_WIDTH    (IRW),
    .DR_WIDTH    (DRW),
    .SYNC_STAGES (SS),
    .ACT_BIT     (AB),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [IRW-1:0] ir, input logic [DRW-1:0] data);
    exp_t e;
    logic [NCH-1:0] oh;
    oh     = '0;
    oh[ir] = 1'b1;
    e.ta   = data[AB] ? oh : '0;
    e.tna  = data[AB] ? '0 : oh;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic send_udr(input logic [IRW-1:0] ir, input logic [DRW-1:0] data, input bit kept);
    bus.ir_in = ir;
    bus.sr    = data;
    if (kept) push_cmd(ir, data);
    bus.vs_udr = 1'b1;
    tick(3);
    bus.vs_udr = 1'b0;
    tick(4);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && bus.cmd_valid !== 1'b1; i++) tick(1);
    check_val(tag, bus.cmd_valid, 1);
  endtask

  // pulse monitor: every emitted pulse must match the oldest queued command
  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1 && (|bus.take_action || |bus.take_no_action)) begin
      if (sb.size() == 0) begin
        check_val("spurious_pulse", {bus.take_action, bus.take_no_action}, 0);
      end else begin
        e = sb.pop_front();
        check_val("sb_take_action", bus.take_action, e.ta);
        check_val("sb_take_no_action", bus.take_no_action, e.tna);
        check_val("sb_jdo", bus.jdo, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DRW-1:0] a_cmd;
    logic [DRW-1:0] d_cmd;
    reset_n         = 1'b0;
    bus.vs_udr      = 1'b0;
    bus.vs_uir      = 1'b0;
    bus.ir_in       = '0;
    bus.sr          = '0;
    bus.cmd_ready   = 1'b0;
    bus.clr_overrun = 1'b0;
    tick(3);
    check_val("rst_cmd_valid", bus.cmd_valid, 0);
    check_val("rst_jdo", bus.jdo, 0);
    check_val("rst_pulses", {bus.take_action, bus.take_no_action}, 0);
    check_val("rst_ir_update", bus.ir_update, 0);
    check_val("rst_overrun", bus.overrun, 0);
    check_val("rst_drop_count", bus.drop_count, 0);
    reset_n = 1'b1;
    tick(5);

    // action command: pulse appears SYNC_STAGES edges after first sample
    bus.cmd_ready = 1'b1;
    bus.ir_in     = 2'd2;
    bus.sr        = 38'h04_0000_0ABC;
    push_cmd(2'd2, 38'h04_0000_0ABC);
    bus.vs_udr = 1'b1;
    tick(1);
    check_val("s1_valid_e0", bus.cmd_valid, 0);
    tick(1);
    check_val("s1_valid_e1", {bus.cmd_valid, bus.take_action}, 0);
    tick(1);
    check_val("s1_take_action", bus.take_action, 4'b0100);
    check_val("s1_jdo", bus.jdo, 38'h04_0000_0ABC);
    tick(1);
    check_val("s1_after", {bus.cmd_valid, bus.take_action}, 0);
    check_val("s1_jdo_hold", bus.jdo, 38'h04_0000_0ABC);
    bus.vs_udr = 1'b0;
    tick(4);

    // bit 33 set but action bit clear
    send_udr(2'd3, 38'h02_0000_0ABC, 1'b1);

    // ir_update timing and no effect on the command path
    bus.vs_uir = 1'b1;
    tick(1);
    check_val("uir_e0", bus.ir_update, 0);
    tick(1);
    check_val("uir_e1", bus.ir_update, 0);
    tick(1);
    check_val("uir_e2", bus.ir_update, 1);
    tick(1);
    check_val("uir_e3", {bus.ir_update, bus.cmd_valid}, 0);
    bus.vs_uir = 1'b0;
    tick(4);

    // held command with consumer stalled
    bus.cmd_ready = 1'b0;
    send_udr(2'd1, 38'h00_1234_5678, 1'b1);
    wait_valid("s2_valid");
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check_val("s2_hold", {bus.cmd_valid, bus.take_action, bus.take_no_action}, {1'b1, 8'h00});
    end
    check_val("s2_jdo", bus.jdo, 38'h00_1234_5678);
    bus.cmd_ready = 1'b1;
    #1;
    check_val("s2_take_no_action", bus.take_no_action, 4'b0010);
    tick(1);
    check_val("s2_after", {bus.cmd_valid, bus.take_no_action}, 0);

    // three drops while pending, then clear
    bus.cmd_ready = 1'b0;
    a_cmd = 38'h04_AAAA_5555;
    send_udr(2'd0, a_cmd, 1'b1);
    wait_valid("s3_valid");
    for (int i = 0; i < 3; i++) send_udr(IRW'($urandom_range(0, 3)), DRW'($urandom) ^ 38'h3F_0000_0000, 1'b0);
    check_val("s3_overrun", bus.overrun, 1);
    check_val("s3_drop_count", bus.drop_count, 3);
    check_val("s3_jdo", bus.jdo, a_cmd);
    bus.clr_overrun = 1'b1;
    tick(1);
    bus.clr_overrun = 1'b0;
    check_val("s3_clr", {bus.overrun, bus.drop_count}, 0);
    check_val("s3_still_valid", bus.cmd_valid, 1);
    bus.cmd_ready = 1'b1;
    tick(1);
    check_val("s3_drained", bus.cmd_valid, 0);

    // saturation of the 2-bit counter and clear priority over a drop
    bus.cmd_ready = 1'b0;
    send_udr(2'd3, 38'h00_0000_0BBB, 1'b1);
    wait_valid("s4_valid");
    send_udr(2'd1, 38'h11_1111_1111, 1'b0);
    check_val("s4_count1", bus.drop_count, 1);
    for (int i = 0; i < 4; i++) send_udr(2'd2, 38'h22_2222_2222, 1'b0);
    check_val("s4_saturated", bus.drop_count, 3);
    check_val("s4_overrun", bus.overrun, 1);
    bus.clr_overrun = 1'b1;
    send_udr(2'd0, 38'h33_3333_3333, 1'b0);
    bus.clr_overrun = 1'b0;
    check_val("s4_clr_priority", {bus.overrun, bus.drop_count}, 0);
    check_val("s4_jdo", bus.jdo, 38'h00_0000_0BBB);
    bus.cmd_ready = 1'b1;
    tick(1);
    check_val("s4_drained", bus.cmd_valid, 0);

    // new edge in the same cycle as a transfer
    bus.cmd_ready = 1'b0;
    send_udr(2'd1, 38'h04_0000_00C5, 1'b1);
    wait_valid("s5_valid");
    d_cmd     = 38'h00_0000_00D7;
    bus.ir_in = 2'd2;
    bus.sr    = d_cmd;
    push_cmd(2'd2, d_cmd);
    bus.vs_udr = 1'b1;
    tick(1);
    tick(1);
    bus.cmd_ready = 1'b1;
    #1;
    check_val("s5_first_pulse", bus.take_action, 4'b0010);
    tick(1);
    check_val("s5_still_valid", bus.cmd_valid, 1);
    check_val("s5_overrun", bus.overrun, 0);
    check_val("s5_jdo", bus.jdo, d_cmd);
    tick(1);
    check_val("s5_drained", bus.cmd_valid, 0);
    bus.vs_udr = 1'b0;
    tick(4);

    // reset while pending, strobe held high across release
    bus.cmd_ready = 1'b0;
    send_udr(2'd2, 38'h04_0000_0F0F, 1'b0);
    wait_valid("s6_valid");
    send_udr(2'd1, 38'h00_0000_0E0E, 1'b0);
    check_val("s6_pre_overrun", bus.overrun, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("s6_rst_valid", bus.cmd_valid, 0);
    check_val("s6_rst_jdo", bus.jdo, 0);
    check_val("s6_rst_flags", {bus.overrun, bus.drop_count, bus.ir_update}, 0);
    check_val("s6_rst_pulses", {bus.take_action, bus.take_no_action}, 0);
    bus.vs_udr    = 1'b1;
    bus.cmd_ready = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(12);
    check_val("s6_no_edge", bus.cmd_valid, 0);
    bus.vs_udr = 1'b0;
    tick(4);
    send_udr(2'd0, 38'h04_0000_0777, 1'b1);
    tick(3);

    check_val("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
